// File: rtl/uart_rx.sv
// uart_rx: serial byte receiver (start, 8 data bits LSB first, stop) with mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit and report parity_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data_i,
  output logic       receive_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ack_q, ack_d;
  logic             ferr_q, ferr_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rxd_prev_q, rxd_prev_d;
  logic             rxd_s;
`ifdef UART_RX_PARITY_EN
  logic             perr_q, perr_d;
  logic             par_bad_q, par_bad_d;
`endif

  assign rxd_s = sync2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    ack_d      = 1'b0;
    ferr_d     = 1'b0;
    sync1_d    = rxd;
    sync2_d    = sync1_q;
    rxd_prev_d = rxd_s;
`ifdef UART_RX_PARITY_EN
    perr_d     = 1'b0;
    par_bad_d  = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Only a 1->0 transition starts a frame, so a line stuck low stays idle.
        if (rxd_prev_q && !rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = rxd_s ^ (^shift_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at mid stop bit so a following start edge is never missed.
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s) begin
            data_d = shift_q;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) perr_d = 1'b1;
            else           ack_d  = 1'b1;
`else
            ack_d = 1'b1;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      ferr_q     <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      par_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      ferr_q     <= ferr_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rxd_prev_q <= rxd_prev_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  assign data_i      = data_q;
  assign receive_ack = ack_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table-driven frames, hand-written corner sequences, randomized frames vs. a frame-level model.
module tb_uart_rx;
  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int FRAME_BITS = PARITY_ON ? 11 : 10;
  // Start edge to pulse: last bit's mid-sample (FRAME_BITS-0.5 periods), 2 sync flops, 1 output register.
  localparam int LAT = (FRAME_BITS - 1) * N + N / 2 + 3;
  localparam int K_ACK = 0, K_PERR = 1, K_FERR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data_i;
  logic       receive_ack, parity_err, frame_err, busy;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .data_i(data_i),
    .receive_ack(receive_ack), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_ack = 0, n_perr = 0, n_ferr = 0, excl_viol = 0, last_cyc = 0;
  logic [7:0] ack_log[$];
  always @(negedge clk) begin
    if (receive_ack) begin n_ack++; ack_log.push_back(data_i); end
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (receive_ack || parity_err || frame_err) last_cyc = cyc;
    if (int'(receive_ack) + int'(parity_err) + int'(frame_err) > 1) excl_viol++;
  end

  int n_tests = 0, n_fail = 0;
  int s_ack, s_perr, s_ferr, start_cyc;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic snap();
    s_ack = n_ack; s_perr = n_perr; s_ferr = n_ferr;
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rxd = b;
    repeat (N - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    @(negedge clk);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (N - 1) @(negedge clk);
    for (int b = 0; b < 8; b++) drive_bit(d[b]);
    if (PARITY_ON) drive_bit(p);
    drive_bit(s);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin @(negedge clk); rxd = 1'b1; end
  endtask

  // Frame-level model: a low stop bit is a framing error, else a parity mismatch (if enabled), else a good byte.
  function automatic int ref_kind(input logic [7:0] d, input logic p, input logic s);
    if (!s) return K_FERR;
    if (PARITY_ON && (p != ^d)) return K_PERR;
    return K_ACK;
  endfunction

  task automatic check_frame(input string name, input int kind, input logic [7:0] exp_data);
    check({name, "_ack"},  n_ack - s_ack,   (kind == K_ACK)  ? 1 : 0);
    check({name, "_perr"}, n_perr - s_perr, (kind == K_PERR) ? 1 : 0);
    check({name, "_ferr"}, n_ferr - s_ferr, (kind == K_FERR) ? 1 : 0);
    check({name, "_data"}, int'(data_i), int'(exp_data));
    check({name, "_lat"},  last_cyc - start_cyc, LAT);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         kind;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [7:0] model_data;
    int         busy_cnt;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, K_ACK, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, PARITY_ON ? K_PERR : K_ACK, 8'h3C};
    vecs[2] = '{8'h81, 1'b0, 1'b0, K_FERR, 8'h3C};

    repeat (4) @(negedge clk);
    check("rst_data", int'(data_i), 0);
    check("rst_ack",  int'(receive_ack), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(2 * N);

    for (int i = 0; i < 3; i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      check_frame($sformatf("vec%0d", i), vecs[i].kind, vecs[i].exp_data);
      idle(2 * N);
    end

    // Framing error followed by a line held low: no new frame may start.
    snap();
    send_frame(8'h81, 1'b0, 1'b0);
    check_frame("ferr_seq", K_FERR, 8'h3C);
    busy_cnt = 0;
    repeat (3 * N) begin @(negedge clk); rxd = 1'b0; if (busy) busy_cnt++; end
    check("ferr_low_busy", busy_cnt, 0);
    idle(N);
    snap();
    send_frame(8'h42, 1'b0, 1'b1);
    check_frame("after_ferr", K_ACK, 8'h42);
    idle(2 * N);

    // Short low glitch on an idle line.
    snap();
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rxd = (i < 4) ? 1'b0 : 1'b1;
      if (busy) busy_cnt++;
    end
    check("glitch_busy_seen", (busy_cnt >= 1) ? 1 : 0, 1);
    check("glitch_busy_max", (busy_cnt <= 10) ? 1 : 0, 1);
    check("glitch_busy_end", int'(busy), 0);
    check("glitch_pulses", (n_ack - s_ack) + (n_perr - s_perr) + (n_ferr - s_ferr), 0);

    // Back-to-back frames with no idle gap.
    snap();
    send_frame(8'h00, 1'b0, 1'b1);
    check_frame("b2b_first", K_ACK, 8'h00);
    send_frame(8'hFF, 1'b0, 1'b1);
    check("b2b_ack_count", n_ack - s_ack, 2);
    check("b2b_log0", int'(ack_log[s_ack]), 8'h00);
    check("b2b_log1", int'(ack_log[s_ack + 1]), 8'hFF);
    check("b2b_data", int'(data_i), 8'hFF);
    idle(2 * N);

    // Reset pulse in the middle of data bit 3 of 0x5A (bit 3 = 1, so the line stays high after it).
    snap();
    @(negedge clk);
    rxd = 1'b0;
    repeat (N - 1) @(negedge clk);
    for (int b = 0; b < 3; b++) drive_bit(b[0] ? 1'b1 : 1'b0 ^ 1'b0);
    @(negedge clk);
    rxd = 1'b1;
    repeat (N / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_data", int'(data_i), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_flags", int'(receive_ack) + int'(parity_err) + int'(frame_err), 0);
    idle(3 * N);
    check("midrst_no_pulse", (n_ack - s_ack) + (n_perr - s_perr) + (n_ferr - s_ferr), 0);
    snap();
    send_frame(8'hFF, 1'b0, 1'b1);
    check_frame("post_rst", K_ACK, 8'hFF);
    idle(N);

    // Randomized frames against the frame-level model.
    model_data = 8'hFF;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       p, s;
      int         kind, gap;
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      kind = ref_kind(d, p, s);
      if (kind != K_FERR) model_data = d;
      snap();
      send_frame(d, p, s);
      check_frame($sformatf("rnd%0d", i), kind, model_data);
      gap = int'($urandom_range((kind == K_FERR) ? 2 : 0, 2 * N));
      idle(gap);
    end

    idle(N);
    check("exclusive_pulses", excl_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
